// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution datapath and its loop sequencer.
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } conv_seq_state_t;

    function automatic int k_bits_f(input int maxk);
        return $clog2(maxk + 1);
    endfunction

    function automatic int xa_f(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

    function automatic int wa_f(input int maxk);
        return $clog2(maxk * maxk);
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Per-lane X/W read addresses and lane mask for one MAC beat; purely combinational.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter  int R      = 16,
    parameter  int C      = 17,
    parameter  int MAXK   = 9,
    parameter  int LANES  = 3,
    localparam int K_BITS = k_bits_f(MAXK),
    localparam int XA     = xa_f(R, C),
    localparam int WA     = wa_f(MAXK),
    localparam int RW     = $clog2(R) + 1,
    localparam int CW     = $clog2(C) + 1
) (
    input  logic                  i_en,
    input  logic [RW-1:0]         i_r,
    input  logic [CW-1:0]         i_c,
    input  logic [K_BITS-1:0]     i_i,
    input  logic [K_BITS-1:0]     i_j,
    input  logic [K_BITS-1:0]     i_k,
    output logic [LANES*XA-1:0]   o_x_addr,
    output logic [LANES*WA-1:0]   o_w_addr,
    output logic [LANES-1:0]      o_lane_mask
);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic          w_live;
        logic [XA-1:0] w_x;
        logic [WA-1:0] w_w;

        // Full-width integer arithmetic first, then truncate to the memory address width.
        assign w_live = i_en && (int'(i_j) + l < int'(i_k));
        assign w_x    = XA'((int'(i_r) + int'(i_i)) * C + int'(i_c) + int'(i_j) + l);
        assign w_w    = WA'(int'(i_i) * int'(i_k) + int'(i_j) + l);

        assign o_lane_mask[l]         = w_live;
        assign o_x_addr[l*XA +: XA]   = w_live ? w_x : '0;
        assign o_w_addr[l*WA +: WA]   = w_live ? w_w : '0;
    end

endmodule

// File: rtl/conv_loop_sequencer.sv
// Window/tap loop controller: issues LANES-wide MAC beats, waits out the MAC pipeline,
// then offers each window result to the output FIFO.
module conv_loop_sequencer
    import conv_pkg::*;
#(
    parameter  int R       = 16,
    parameter  int C       = 17,
    parameter  int MAXK    = 9,
    parameter  int LANES   = 3,
    parameter  int MAC_LAT = 2,
    localparam int K_BITS  = k_bits_f(MAXK),
    localparam int XA      = xa_f(R, C),
    localparam int WA      = wa_f(MAXK),
    localparam int RW      = $clog2(R) + 1,
    localparam int CW      = $clog2(C) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [K_BITS-1:0]   k_in,
    output logic                cfg_err,
    output logic                busy,
    output logic [LANES*XA-1:0] x_addr,
    output logic [LANES*WA-1:0] w_addr,
    output logic                mac_valid,
    output logic                first_product,
    output logic [LANES-1:0]    lane_mask,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [RW-1:0]       res_row,
    output logic [CW-1:0]       res_col,
    output logic                done
);

    localparam int DW = $clog2(MAC_LAT + 1);

    conv_seq_state_t    r_state;
    logic [RW-1:0]      r_r;
    logic [CW-1:0]      r_c;
    logic [K_BITS-1:0]  r_i, r_j, r_k;
    logic [DW-1:0]      r_drain;
    logic               r_cfg_err;

    logic w_k_bad, w_j_wrap, w_i_last, w_last_beat, w_col_end, w_last_win;
    logic w_run, w_write;

    assign w_k_bad     = (k_in == '0) || (int'(k_in) > MAXK) || (int'(k_in) > R) || (int'(k_in) > C);
    assign w_j_wrap    = (int'(r_j) + LANES) >= int'(r_k);
    assign w_i_last    = int'(r_i) == int'(r_k) - 1;
    assign w_last_beat = w_j_wrap && w_i_last;
    assign w_col_end   = int'(r_c) == C - int'(r_k);
    assign w_last_win  = w_col_end && (int'(r_r) == R - int'(r_k));

    // NOTE: every register below is assigned with <= so all of them update from the
    // same pre-edge values; a blocking '=' here would let later lines see new values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_r       <= '0;
            r_c       <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_drain   <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_k_bad) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_k     <= k_in;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_j_wrap) begin
                        r_j <= '0;
                        r_i <= w_i_last ? '0 : r_i + K_BITS'(1);
                    end else begin
                        r_j <= r_j + K_BITS'(LANES);
                    end
                    if (w_last_beat) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (int'(r_drain) == MAC_LAT - 1) begin
                        r_drain <= '0;
                        r_state <= S_WRITE;
                    end else begin
                        r_drain <= r_drain + DW'(1);
                    end
                end
                S_WRITE: begin
                    if (res_ready) begin
                        if (w_last_win) begin
                            r_r     <= '0;
                            r_c     <= '0;
                            r_state <= S_DONE;
                        end else begin
                            if (w_col_end) begin
                                r_c <= '0;
                                r_r <= r_r + RW'(1);
                            end else begin
                                r_c <= r_c + CW'(1);
                            end
                            r_state <= S_RUN;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_run         = r_state == S_RUN;
    assign w_write       = r_state == S_WRITE;
    assign busy          = r_state != S_IDLE;
    assign mac_valid     = w_run;
    assign first_product = w_run && (r_i == '0) && (r_j == '0);
    assign res_valid     = w_write;
    assign res_row       = w_write ? r_r : '0;
    assign res_col       = w_write ? r_c : '0;
    assign done          = r_state == S_DONE;
    assign cfg_err       = r_cfg_err;

    conv_addr_gen #(
        .R     (R),
        .C     (C),
        .MAXK  (MAXK),
        .LANES (LANES)
    ) u_addr_gen (
        .i_en        (w_run),
        .i_r         (r_r),
        .i_c         (r_c),
        .i_i         (r_i),
        .i_j         (r_j),
        .i_k         (r_k),
        .o_x_addr    (x_addr),
        .o_w_addr    (w_addr),
        .o_lane_mask (lane_mask)
    );

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Scoreboard bench: a loop-level reference model queues expected beats and results,
// a negedge monitor pops and compares them as the sequencer presents them.
module tb_conv_loop_sequencer;

    localparam int R       = 16;
    localparam int C       = 17;
    localparam int MAXK    = 9;
    localparam int LANES   = 3;
    localparam int MAC_LAT = 2;
    localparam int K_BITS  = $clog2(MAXK + 1);
    localparam int XA      = $clog2(R * C);
    localparam int WA      = $clog2(MAXK * MAXK);
    localparam int RW      = $clog2(R) + 1;
    localparam int CW      = $clog2(C) + 1;

    typedef struct {
        logic                first;
        logic [LANES-1:0]    mask;
        logic [LANES*XA-1:0] xa;
        logic [LANES*WA-1:0] wa;
    } beat_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [K_BITS-1:0]   k_in = '0;
    logic                cfg_err, busy, mac_valid, first_product, res_valid, done;
    logic [LANES*XA-1:0] x_addr;
    logic [LANES*WA-1:0] w_addr;
    logic [LANES-1:0]    lane_mask;
    logic                res_ready = 1'b1;
    logic [RW-1:0]       res_row;
    logic [CW-1:0]       res_col;

    conv_loop_sequencer #(
        .R(R), .C(C), .MAXK(MAXK), .LANES(LANES), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .k_in          (k_in),
        .cfg_err       (cfg_err),
        .busy          (busy),
        .x_addr        (x_addr),
        .w_addr        (w_addr),
        .mac_valid     (mac_valid),
        .first_product (first_product),
        .lane_mask     (lane_mask),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_row       (res_row),
        .res_col       (res_col),
        .done          (done)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    done_cnt = 0;
    int    cfg_cnt = 0;
    int    ready_mode = 0;   // 0: always ready, 1: random, 2: stall window (0,1) five cycles
    int    stall_cnt = 0;
    int    last_row = -1;
    int    last_col = -1;
    beat_t q_beat[$];
    int    q_res[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: every window in raster order, kernel taps row by row, LANES taps per beat.
    task automatic push_run(input int k);
        beat_t b;
        for (int r = 0; r <= R - k; r++) begin
            for (int c = 0; c <= C - k; c++) begin
                for (int i = 0; i < k; i++) begin
                    for (int j = 0; j < k; j += LANES) begin
                        b.first = (i == 0 && j == 0);
                        b.mask  = '0;
                        b.xa    = '0;
                        b.wa    = '0;
                        for (int l = 0; l < LANES; l++) begin
                            if (j + l < k) begin
                                b.mask[l]          = 1'b1;
                                b.xa[l*XA +: XA]   = XA'((r + i) * C + c + j + l);
                                b.wa[l*WA +: WA]   = WA'(i * k + j + l);
                            end
                        end
                        q_beat.push_back(b);
                    end
                end
                q_res.push_back(r * 256 + c);
            end
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: res_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (res_valid && res_row == 0 && res_col == 1 && stall_cnt < 5) begin
                    res_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    res_ready = 1'b1;
                end
            end
            default: res_ready = 1'b1;
        endcase
    end

    logic          prev_hold = 1'b0;
    logic [RW-1:0] prev_row;
    logic [CW-1:0] prev_col;
    beat_t         mb;
    int            mr;

    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", res_valid, 1'b1);
                check("hold_coord", {res_row, res_col}, {prev_row, prev_col});
            end
            if (res_valid) check("no_beat_in_write", mac_valid, 1'b0);
            if (mac_valid) begin
                if (q_beat.size() == 0) begin
                    check("beat_extra", mac_valid, 1'b0);
                end else begin
                    mb = q_beat.pop_front();
                    check("first_product", first_product, mb.first);
                    check("lane_mask", lane_mask, mb.mask);
                    check("x_addr", x_addr, mb.xa);
                    check("w_addr", w_addr, mb.wa);
                end
            end
            if (res_valid && res_ready) begin
                if (q_res.size() == 0) begin
                    check("result_extra", res_valid, 1'b0);
                end else begin
                    mr = q_res.pop_front();
                    check("res_coord", 64'(int'(res_row) * 256 + int'(res_col)), 64'(mr));
                end
                last_row = int'(res_row);
                last_col = int'(res_col);
            end
            if (done) done_cnt++;
            if (cfg_err) cfg_cnt++;
            prev_hold = res_valid && !res_ready;
            prev_row  = res_row;
            prev_col  = res_col;
        end
    end

    task automatic check_idle(input string name);
        check({name, "_ctl"}, {busy, mac_valid, first_product, res_valid, done, cfg_err, lane_mask, res_row, res_col}, '0);
        check({name, "_xaddr"}, x_addr, '0);
        check({name, "_waddr"}, w_addr, '0);
    endtask

    task automatic run(input int k, input int mode, input bit timed, input int extra);
        int w, period, s, done_c, d0, c0;
        bit got;
        w      = (R - k + 1) * (C - k + 1);
        period = k * ((k + LANES - 1) / LANES) + MAC_LAT + 1;
        push_run(k);
        ready_mode = mode;
        stall_cnt  = 0;
        d0 = done_cnt;
        c0 = cfg_cnt;
        done_c = 0;
        @(negedge clk);
        k_in  = K_BITS'(k);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = cyc;
        check($sformatf("first_beat_k%0d", k), mac_valid, 1'b1);
        // A start while running must be ignored, even with an illegal K.
        start = 1'b1;
        k_in  = '0;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int n = 0; n < w * period * 8 + 200; n++) begin
            @(negedge clk);
            if (done) begin
                got    = 1'b1;
                done_c = cyc;
                break;
            end
        end
        check($sformatf("done_seen_k%0d", k), got, 1'b1);
        if (timed && got) check($sformatf("done_cycle_k%0d", k), 64'(done_c - s), 64'(w * period + extra));
        @(negedge clk);
        @(negedge clk);
        check($sformatf("done_pulses_k%0d", k), 64'(done_cnt - d0), 64'd1);
        check($sformatf("no_cfg_err_k%0d", k), 64'(cfg_cnt - c0), 64'd0);
        check($sformatf("idle_after_k%0d", k), busy, 1'b0);
        check($sformatf("beats_left_k%0d", k), 64'(q_beat.size()), 64'd0);
        check($sformatf("results_left_k%0d", k), 64'(q_res.size()), 64'd0);
        ready_mode = 0;
    endtask

    task automatic try_bad(input int k);
        int  c0;
        bit  busy_seen;
        c0 = cfg_cnt;
        busy_seen = 1'b0;
        @(negedge clk);
        k_in  = K_BITS'(k);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_seen |= busy;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            busy_seen |= busy;
        end
        check($sformatf("cfg_err_k%0d", k), 64'(cfg_cnt - c0), 64'd1);
        check($sformatf("busy_bad_k%0d", k), busy_seen, 1'b0);
    endtask

    initial begin
        int d0;
        bit in_drain;

        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle("idle_released");

        run(3, 0, 1'b1, 0);
        run(4, 0, 1'b1, 0);
        run(1, 0, 1'b1, 0);
        check("k1_last_row", 64'(last_row), 64'd15);
        check("k1_last_col", 64'(last_col), 64'd16);

        try_bad(0);
        try_bad(10);

        run(3, 2, 1'b1, 5);
        check("stall_cycles", 64'(stall_cnt), 64'd5);

        run(int'($urandom_range(2, MAXK)), 1, 1'b0, 0);
        run(int'($urandom_range(2, MAXK)), 1, 1'b0, 0);

        // Reset while the MAC pipeline is draining the first window.
        push_run(3);
        @(negedge clk);
        k_in  = K_BITS'(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_drain = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (busy && !mac_valid && !res_valid) begin
                in_drain = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("drain_reached", in_drain, 1'b1);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        check_idle("reset_mid_drain");
        q_beat.delete();
        q_res.delete();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
        check_idle("idle_after_reset");

        run(2, 0, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
